exe: RTL and testbench
======================

Name: exe

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits between decode and the memory stage, and feeds the memory stage's wbi/M/memdatasize/nop_exe/data/dataaddr/regaddr inputs.
- Performs single-cycle ALU operations and owns HI/LO.
- Hosts an iterative 32-cycle multiply/divide unit. Stalls decode when a HI/LO-dependent instruction meets a busy unit.

Parameters:
- MD_CYCLES, 32, iterations per mult/div (one bit per cycle).
- DW, 32, datapath width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  reset; synchronous, active-high.
- wbi  in  2  writeback control from decode.
- mi  in  1  memory-write enable from decode.
- memsizei  in  2  store size code (00 byte … 11 word).
- aluctl  in  5  operation code (package constants).
- opa  in  DW  rs value / shift source.
- opb  in  DW  rt value or extended immediate.
- shamt  in  5  shift amount for immediate shifts.
- storedatai  in  DW  rt value for stores.
- regaddri  in  5  destination register.
- nop_id  in  1  decode slot is a bubble.
- stall  out  1  hold decode/fetch this cycle (combinational).
- wbo  out  2  to memory stage wbi.
- mo  out  1  to memory stage M.
- memsizeo  out  2  to memdatasize.
- nopo  out  1  to nop_exe.
- datao  out  DW  store data.
- resulto  out  DW  ALU result / address, to dataaddr.
- regaddro  out  5  destination register.
- md_busy  out  1  mult/div in progress (debug/forwarding).

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high.
- Reset: all outputs 0 except nopo=1; HI=LO=0; md_busy=0; iteration counter=0.
- Output record latency:
  - One cycle: the registered record is loaded on each posedge from the current inputs.
  - resulto per aluctl: ADD/SUB wrap with no overflow trap; AND, OR, XOR, NOR; SLT signed; SLTU unsigned (result 0/1).
  - Shifts: SLL/SRL/SRA by shamt; SLLV/SRLV/SRAV by opa[4:0] with the shift source in opb.
  - LUI = {opb[15:0],16'b0}; MFHI/MFLO = HI/LO.
- Non-result instructions: MULT, MULTU, DIV, DIVU, MTHI and MTLO pass through with wbo=0 and mo=0, so the memory stage writes nothing.
- Bubbles: nop_id=1 forces nopo=1 and mo=0; wbo passes through. A bubble never starts mult/div and never writes HI/LO.
- Mult/div start: occurs on a non-bubble MULT/MULTU/DIV/DIVU with md_busy=0.
  - Operands latched; md_busy=1; counter=0.
  - Each cycle: one shift-add (mult) or restoring subtract (div) step, then counter++.
  - On the edge where counter reaches MD_CYCLES-1: HI/LO written and md_busy=0. Result is visible to an MFHI issued the following cycle.
- Signed ops: operand magnitudes are used internally; the sign is fixed at the end. DIV remainder takes the dividend's sign.
- Divide by zero: completes normally with LO=32'hFFFFFFFF, HI=dividend. No exception.
- stall=1 whenever md_busy=1 and a non-bubble MFHI, MFLO, MTHI, MTLO, MULT*, or DIV* is at the inputs.
  - While stalled, the output record is a bubble: nopo=1, mo=0, wbo=0.
  - Decode holds its inputs unchanged. stall deasserts in the cycle md_busy falls.
- Independent ALU ops: issue normally while md_busy=1, with no stall.
- MTHI/MTLO: write HI/LO from opa at the posedge; they do not start the unit.
- Reset mid-operation: aborts the mult/div, clears HI/LO, and drops stall the next cycle.
- Unknown aluctl: resulto=0, wbo=0, mo=0.

Decomposition:
- Package exe_defs:
  - aluctl code constants (ALU_ADD…ALU_MTLO, 5-bit);
  - MD_CYCLES;
  - the memsize encodings shared with the memory stage.
- Sub-module exe_muldiv:
  - iterative multiplier/divider with start, op, opa, opb inputs and busy, done, hi, lo outputs;
  - owns the counter, partial product/remainder, and sign-fix logic.
- exe keeps the ALU, the HI/LO registers, stall logic and the output register.

Test Plan:
- ADD opa=7FFFFFFF, opb=1, regaddri=3, wbi=01 -> next cycle resulto=80000000, regaddro=3, wbo=01, nopo=0.
- MULT opa=FFFFFFFE (-2), opb=3; MFLO presented at once -> stall=1 for 32 cycles with nopo=1 records; then resulto=FFFFFFFA, and MFHI gives FFFFFFFF.
- DIVU opa=100, opb=0 -> after 32 cycles LO=FFFFFFFF, HI=00000064; an independent SUB issued at cycle 5 completes without stall.
- Store SW, mi=1, memsizei=11, opa=1000, opb=4, storedatai=DEADBEEF -> resulto=1004, mo=1, datao=DEADBEEF; same with nop_id=1 -> mo=0, nopo=1.
- DIV started, reset asserted at iteration 10 -> next cycle md_busy=0, stall=0, HI=LO=0, nopo=1.
- SRA opb=80000000, shamt=4 -> F8000000; SRLV opa=36 (uses 4), opb=80000000 -> 08000000.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, store size
// encodings and the mult/div operation selector.
package exe_defs;

  localparam int MD_CYCLES = 32;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_SLLV  = 5'd11;
  localparam logic [4:0] ALU_SRLV  = 5'd12;
  localparam logic [4:0] ALU_SRAV  = 5'd13;
  localparam logic [4:0] ALU_LUI   = 5'd14;
  localparam logic [4:0] ALU_MFHI  = 5'd15;
  localparam logic [4:0] ALU_MFLO  = 5'd16;
  localparam logic [4:0] ALU_MULT  = 5'd17;
  localparam logic [4:0] ALU_MULTU = 5'd18;
  localparam logic [4:0] ALU_DIV   = 5'd19;
  localparam logic [4:0] ALU_DIVU  = 5'd20;
  localparam logic [4:0] ALU_MTHI  = 5'd21;
  localparam logic [4:0] ALU_MTLO  = 5'd22;

  localparam logic [1:0] MEMSIZE_BYTE = 2'b00;
  localparam logic [1:0] MEMSIZE_HALF = 2'b01;
  localparam logic [1:0] MEMSIZE_TRI  = 2'b10;
  localparam logic [1:0] MEMSIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_t;

  function automatic logic is_md_op(input logic [4:0] ctl);
    return ctl inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  endfunction

  // Anything that reads, writes or starts the HI/LO unit.
  function automatic logic is_hilo_op(input logic [4:0] ctl);
    return is_md_op(ctl) || (ctl inside {ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO});
  endfunction

endpackage

// File: rtl/exe_muldiv.sv
// Iterative one-bit-per-cycle multiplier / restoring divider working on
// operand magnitudes; signs are applied to the final step's result.
module exe_muldiv
  import exe_defs::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  md_op_t        op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  localparam int CW = $clog2(MD_CYCLES);

  logic            busy_reg;
  logic [CW-1:0]   count_reg;
  logic [2*DW-1:0] acc_reg;    // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [2*DW-1:0] acc_next;
  logic [DW-1:0]   mcand_reg;  // multiplicand or divisor magnitude
  logic            div_reg;
  logic            neg_lo_reg;
  logic            neg_hi_reg;
  logic            dz_reg;

  logic          op_signed;
  logic          op_div;
  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;

  assign op_signed = (op == MD_MULT) || (op == MD_DIV);
  assign op_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg     = op_signed & opa[DW-1];
  assign b_neg     = op_signed & opb[DW-1];
  assign a_mag     = a_neg ? -opa : opa;
  assign b_mag     = b_neg ? -opb : opb;

  logic [DW:0]   sum;
  logic [DW:0]   shl;
  logic [DW-1:0] diff;
  logic          ge;

  always_comb begin
    sum  = {1'b0, acc_reg[2*DW-1:DW]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    shl  = {acc_reg[2*DW-1:DW], acc_reg[DW-1]};
    ge   = shl >= {1'b0, mcand_reg};
    diff = shl[DW-1:0] - mcand_reg;
    if (div_reg) begin
      acc_next = {(ge ? diff : shl[DW-1:0]), acc_reg[DW-2:0], ge};
    end else begin
      acc_next = {sum, acc_reg[DW-1:1]};
    end
  end

  assign done = busy_reg && (count_reg == CW'(MD_CYCLES - 1));
  assign busy = busy_reg;

  logic [2*DW-1:0] prod;
  logic [DW-1:0]   quo;
  logic [DW-1:0]   rem;

  always_comb begin
    prod = neg_lo_reg ? -acc_next : acc_next;
    quo  = acc_next[DW-1:0];
    rem  = acc_next[2*DW-1:DW];
    if (div_reg) begin
      lo = dz_reg ? '1 : (neg_lo_reg ? -quo : quo);
      hi = neg_hi_reg ? -rem : rem;
    end else begin
      lo = prod[DW-1:0];
      hi = prod[2*DW-1:DW];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg   <= 1'b0;
      count_reg  <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      div_reg    <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      dz_reg     <= 1'b0;
    end else if (start && !busy_reg) begin
      busy_reg   <= 1'b1;
      count_reg  <= '0;
      acc_reg    <= {{DW{1'b0}}, (op_div ? a_mag : b_mag)};
      mcand_reg  <= op_div ? b_mag : a_mag;
      div_reg    <= op_div;
      neg_lo_reg <= a_neg ^ b_neg;
      neg_hi_reg <= op_div ? a_neg : (a_neg ^ b_neg);
      dz_reg     <= op_div && (opb == '0);
    end else if (busy_reg) begin
      acc_reg   <= acc_next;
      count_reg <= done ? '0 : count_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/exe.sv
// MIPS execute stage: single-cycle ALU, HI/LO registers, decode stall for
// HI/LO hazards against the iterative mult/div unit, and the EX/MEM record.
module exe
  import exe_defs::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    wbi,
  input  logic          mi,
  input  logic [1:0]    memsizei,
  input  logic [4:0]    aluctl,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [4:0]    shamt,
  input  logic [DW-1:0] storedatai,
  input  logic [4:0]    regaddri,
  input  logic          nop_id,
  output logic          stall,
  output logic [1:0]    wbo,
  output logic          mo,
  output logic [1:0]    memsizeo,
  output logic          nopo,
  output logic [DW-1:0] datao,
  output logic [DW-1:0] resulto,
  output logic [4:0]    regaddro,
  output logic          md_busy
);

  logic [DW-1:0] hi_reg;
  logic [DW-1:0] lo_reg;
  logic          md_done;
  logic [DW-1:0] md_hi;
  logic [DW-1:0] md_lo;
  logic          md_start;
  md_op_t        md_op;

  assign stall    = md_busy && !nop_id && is_hilo_op(aluctl);
  assign md_start = !nop_id && !md_busy && is_md_op(aluctl);

  always_comb begin
    case (aluctl)
      ALU_MULTU: md_op = MD_MULTU;
      ALU_DIV:   md_op = MD_DIV;
      ALU_DIVU:  md_op = MD_DIVU;
      default:   md_op = MD_MULT;
    endcase
  end

  exe_muldiv #(.DW(DW)) u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (md_start),
    .op    (md_op),
    .opa   (opa),
    .opb   (opb),
    .busy  (md_busy),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  logic [DW-1:0] alu_result;
  logic          has_result;  // instruction writes a register (or forms an address)

  always_comb begin
    alu_result = '0;
    has_result = 1'b1;
    case (aluctl)
      ALU_ADD:  alu_result = opa + opb;
      ALU_SUB:  alu_result = opa - opb;
      ALU_AND:  alu_result = opa & opb;
      ALU_OR:   alu_result = opa | opb;
      ALU_XOR:  alu_result = opa ^ opb;
      ALU_NOR:  alu_result = ~(opa | opb);
      ALU_SLT:  alu_result = {{(DW-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_result = {{(DW-1){1'b0}}, opa < opb};
      ALU_SLL:  alu_result = opb << shamt;
      ALU_SRL:  alu_result = opb >> shamt;
      ALU_SRA:  alu_result = $signed(opb) >>> shamt;
      ALU_SLLV: alu_result = opb << opa[4:0];
      ALU_SRLV: alu_result = opb >> opa[4:0];
      ALU_SRAV: alu_result = $signed(opb) >>> opa[4:0];
      ALU_LUI:  alu_result = {opb[15:0], 16'b0};
      ALU_MFHI: alu_result = hi_reg;
      ALU_MFLO: alu_result = lo_reg;
      default:  has_result = 1'b0;
    endcase
  end

  logic [1:0]    wb_next;
  logic          m_next;
  logic          nop_next;

  assign wb_next  = (stall || !has_result) ? 2'b00 : wbi;
  assign m_next   = stall || nop_id || !has_result ? 1'b0 : mi;
  assign nop_next = stall || nop_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      wbo      <= 2'b00;
      mo       <= 1'b0;
      memsizeo <= 2'b00;
      nopo     <= 1'b1;
      datao    <= '0;
      resulto  <= '0;
      regaddro <= '0;
    end else begin
      wbo      <= wb_next;
      mo       <= m_next;
      memsizeo <= memsizei;
      nopo     <= nop_next;
      datao    <= storedatai;
      resulto  <= alu_result;
      regaddro <= regaddri;
    end
  end

  // MTHI/MTLO can never coincide with md_done: while busy they are stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (md_done) begin
      hi_reg <= md_hi;
      lo_reg <= md_lo;
    end else if (!nop_id && !stall) begin
      if (aluctl == ALU_MTHI) hi_reg <= opa;
      if (aluctl == ALU_MTLO) lo_reg <= opa;
    end
  end

endmodule

// File: tb/tb_exe.sv
// Directed bench for the execute stage: ALU vector table plus hand-written
// mult/div, stall and mid-operation reset sequences.
module tb_exe;
  import exe_defs::*;

  logic        clk;
  logic        reset;
  logic [1:0]  wbi;
  logic        mi;
  logic [1:0]  memsizei;
  logic [4:0]  aluctl;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [4:0]  shamt;
  logic [31:0] storedatai;
  logic [4:0]  regaddri;
  logic        nop_id;
  logic        stall;
  logic [1:0]  wbo;
  logic        mo;
  logic [1:0]  memsizeo;
  logic        nopo;
  logic [31:0] datao;
  logic [31:0] resulto;
  logic [4:0]  regaddro;
  logic        md_busy;

  exe #(.DW(32)) dut (
    .clk(clk), .reset(reset), .wbi(wbi), .mi(mi), .memsizei(memsizei),
    .aluctl(aluctl), .opa(opa), .opb(opb), .shamt(shamt),
    .storedatai(storedatai), .regaddri(regaddri), .nop_id(nop_id),
    .stall(stall), .wbo(wbo), .mo(mo), .memsizeo(memsizeo), .nopo(nopo),
    .datao(datao), .resulto(resulto), .regaddro(regaddro), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [1:0] wb, input logic m,
                        input logic [1:0] ms, input logic [31:0] sd, input logic [4:0] rd,
                        input logic nop);
    aluctl = ctl; opa = a; opb = b; shamt = sh; wbi = wb; mi = m;
    memsizei = ms; storedatai = sd; regaddri = rd; nop_id = nop;
  endtask

  task automatic bubble();
    set_in(ALU_ADD, 32'd0, 32'd0, 5'd0, 2'b00, 1'b0, 2'b00, 32'd0, 5'd0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a non-bubble MFHI/MFLO and check the returned value.
  task automatic read_hilo(input logic [4:0] ctl, input string name, input logic [31:0] exp);
    set_in(ctl, 32'd0, 32'd0, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd9, 1'b0);
    #1 chk({name, "_stall"}, {31'd0, stall}, 32'd0);
    tick();
    chk(name, resulto, exp);
    $display("txn %s result %h", name, resulto);
  endtask

  // Start a mult/div, run bubbles until done, then read LO and HI.
  task automatic run_md(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    set_in(ctl, a, b, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd2, 1'b0);
    #1 chk({name, "_start_stall"}, {31'd0, stall}, 32'd0);
    tick();
    chk({name, "_busy"}, {31'd0, md_busy}, 32'd1);
    chk({name, "_wbo"}, {30'd0, wbo}, 32'd0);
    bubble();
    n = 0;
    while (md_busy && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_cycles"}, n, 32'd32);
    read_hilo(ALU_MFLO, {name, "_lo"}, exp_lo);
    read_hilo(ALU_MFHI, {name, "_hi"}, exp_hi);
  endtask

  typedef struct {
    logic [4:0]  ctl;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [1:0]  wb;
    logic        m;
    logic [1:0]  ms;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        nop;
    logic        cr;       // compare resulto for this vector
    logic [31:0] exp_res;
    logic [1:0]  exp_wb;
    logic        exp_m;
    logic        exp_nop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                              input logic [4:0] sh, input logic [1:0] wb, input logic m,
                              input logic [1:0] ms, input logic [31:0] sd, input logic [4:0] rd,
                              input logic nop, input logic cr, input logic [31:0] er,
                              input logic [1:0] ew, input logic em, input logic en);
    vec_t v;
    v.ctl = ctl; v.a = a; v.b = b; v.sh = sh; v.wb = wb; v.m = m; v.ms = ms; v.sd = sd;
    v.rd = rd; v.nop = nop; v.cr = cr; v.exp_res = er; v.exp_wb = ew; v.exp_m = em; v.exp_nop = en;
    return v;
  endfunction

  initial begin
    int n;
    //                 ctl        opa           opb           sh  wb  m  ms  storedata     rd nop cr  exp_res       ewb em en
    vecs.push_back(mk(ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 0, 1, 0, 0, 32'h0,        3, 0, 1, 32'h80000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SUB,  32'h00000005, 32'h00000007, 0, 1, 0, 0, 32'h0,        4, 0, 1, 32'hFFFFFFFE, 1, 0, 0));
    vecs.push_back(mk(ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 0, 0, 32'h0,        5, 0, 1, 32'hF000F000, 1, 0, 0));
    vecs.push_back(mk(ALU_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 0, 0, 32'h0,        6, 0, 1, 32'hFFF0FFF0, 1, 0, 0));
    vecs.push_back(mk(ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 0, 0, 32'h0,        7, 0, 1, 32'h0FF00FF0, 1, 0, 0));
    vecs.push_back(mk(ALU_NOR,  32'h00000000, 32'h00000000, 0, 1, 0, 0, 32'h0,        8, 0, 1, 32'hFFFFFFFF, 1, 0, 0));
    vecs.push_back(mk(ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 0, 1, 0, 0, 32'h0,        9, 0, 1, 32'h00000001, 1, 0, 0));
    vecs.push_back(mk(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 0, 1, 0, 0, 32'h0,       10, 0, 1, 32'h00000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SLL,  32'h0,        32'h00000001, 31, 1, 0, 0, 32'h0,      11, 0, 1, 32'h80000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SRL,  32'h0,        32'h80000000, 4, 1, 0, 0, 32'h0,       12, 0, 1, 32'h08000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SRA,  32'h0,        32'h80000000, 4, 1, 0, 0, 32'h0,       13, 0, 1, 32'hF8000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SRLV, 32'd36,       32'h80000000, 0, 1, 0, 0, 32'h0,       14, 0, 1, 32'h08000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SRAV, 32'h00000021, 32'h80000000, 9, 1, 0, 0, 32'h0,       15, 0, 1, 32'hC0000000, 1, 0, 0));
    vecs.push_back(mk(ALU_SLLV, 32'h00000002, 32'h00000003, 7, 1, 0, 0, 32'h0,       16, 0, 1, 32'h0000000C, 1, 0, 0));
    vecs.push_back(mk(ALU_LUI,  32'h00000005, 32'h0000ABCD, 0, 1, 0, 0, 32'h0,       17, 0, 1, 32'hABCD0000, 1, 0, 0));
    vecs.push_back(mk(ALU_ADD,  32'h00001000, 32'h00000004, 0, 0, 1, 3, 32'hDEADBEEF, 0, 0, 1, 32'h00001004, 0, 1, 0));
    vecs.push_back(mk(ALU_ADD,  32'h00001000, 32'h00000004, 0, 0, 1, 3, 32'hDEADBEEF, 0, 1, 1, 32'h00001004, 0, 0, 1));
    vecs.push_back(mk(ALU_ADD,  32'h00000001, 32'h00000001, 0, 1, 0, 1, 32'h0,       18, 1, 1, 32'h00000002, 1, 0, 1));
    vecs.push_back(mk(5'd31,    32'h00000005, 32'h00000006, 0, 1, 1, 2, 32'h0,       19, 0, 1, 32'h00000000, 0, 0, 0));
    vecs.push_back(mk(ALU_MTHI, 32'h12345678, 32'h0,        0, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(ALU_MTLO, 32'h9ABCDEF0, 32'h0,        0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(ALU_MFHI, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       20, 0, 1, 32'h12345678, 1, 0, 0));
    vecs.push_back(mk(ALU_MFLO, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       21, 0, 1, 32'h9ABCDEF0, 1, 0, 0));
    vecs.push_back(mk(ALU_MTHI, 32'h0,        32'h0,        0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h0,        0, 0, 1));
    vecs.push_back(mk(ALU_MFHI, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       22, 0, 1, 32'h12345678, 1, 0, 0));

    // Reset state
    reset = 1'b1;
    bubble();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nopo", {31'd0, nopo}, 32'd1);
    chk("rst_wbo", {30'd0, wbo}, 32'd0);
    chk("rst_mo", {31'd0, mo}, 32'd0);
    chk("rst_result", resulto, 32'd0);
    chk("rst_busy", {31'd0, md_busy}, 32'd0);
    reset = 1'b0;
    read_hilo(ALU_MFHI, "rst_hi", 32'd0);

    // ALU vector table
    foreach (vecs[i]) begin
      set_in(vecs[i].ctl, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].wb, vecs[i].m,
             vecs[i].ms, vecs[i].sd, vecs[i].rd, vecs[i].nop);
      #1 chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
      tick();
      if (vecs[i].cr) chk($sformatf("v%0d_result", i), resulto, vecs[i].exp_res);
      chk($sformatf("v%0d_wbo", i), {30'd0, wbo}, {30'd0, vecs[i].exp_wb});
      chk($sformatf("v%0d_mo", i), {31'd0, mo}, {31'd0, vecs[i].exp_m});
      chk($sformatf("v%0d_nopo", i), {31'd0, nopo}, {31'd0, vecs[i].exp_nop});
      chk($sformatf("v%0d_rd", i), {27'd0, regaddro}, {27'd0, vecs[i].rd});
      chk($sformatf("v%0d_datao", i), datao, vecs[i].sd);
      chk($sformatf("v%0d_msize", i), {30'd0, memsizeo}, {30'd0, vecs[i].ms});
      $display("txn vec %0d ctl %0d result %h wbo %0d mo %0d nopo %0d", i, vecs[i].ctl, resulto, wbo, mo, nopo);
    end

    // MULT -2*3 with an MFLO right behind it: 32 stalled bubble records
    set_in(ALU_MULT, 32'hFFFFFFFE, 32'h3, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd1, 1'b0);
    tick();
    chk("mult_busy", {31'd0, md_busy}, 32'd1);
    set_in(ALU_MFLO, 32'd0, 32'd0, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd6, 1'b0);
    n = 0;
    #1;
    while (stall && n < 40) begin
      tick();
      n++;
      if (nopo !== 1'b1 || wbo !== 2'b00 || mo !== 1'b0)
        chk("mult_stall_record", {28'd0, nopo, wbo, mo}, 32'h8);
    end
    chk("mult_stall_cycles", n, 32'd32);
    tick();
    chk("mult_mflo", resulto, 32'hFFFFFFFA);
    chk("mult_mflo_nopo", {31'd0, nopo}, 32'd0);
    $display("txn mult stalls %0d lo %h", n, resulto);
    read_hilo(ALU_MFHI, "mult_mfhi", 32'hFFFFFFFF);

    // DIVU 100/0 with an independent SUB issued at the fifth cycle
    set_in(ALU_DIVU, 32'd100, 32'd0, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd1, 1'b0);
    tick();
    n = 0;
    while (md_busy && n < 40) begin
      if (n == 4) set_in(ALU_SUB, 32'd10, 32'd3, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd7, 1'b0);
      else bubble();
      #1;
      if (n == 4) chk("divu_sub_stall", {31'd0, stall}, 32'd0);
      tick();
      if (n == 4) begin
        chk("divu_sub_result", resulto, 32'd7);
        chk("divu_sub_nopo", {31'd0, nopo}, 32'd0);
        chk("divu_sub_busy", {31'd0, md_busy}, 32'd1);
      end
      n++;
    end
    chk("divu_cycles", n, 32'd32);
    read_hilo(ALU_MFLO, "divu_lo", 32'hFFFFFFFF);
    read_hilo(ALU_MFHI, "divu_hi", 32'h00000064);

    // Further mult/div corners
    run_md(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu", 32'hFFFFFFFE, 32'h00000001);
    run_md(ALU_DIV,   32'hFFFFFFF9, 32'h00000002, "div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md(ALU_DIV,   32'h00000007, 32'hFFFFFFFE, "div_negb", 32'h00000001, 32'hFFFFFFFD);
    run_md(ALU_DIV,   32'hFFFFFFF8, 32'h00000000, "div_zero", 32'hFFFFFFF8, 32'hFFFFFFFF);

    // Reset in the middle of a DIV
    set_in(ALU_DIV, 32'hFFFFFFF9, 32'h2, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd1, 1'b0);
    tick();
    bubble();
    repeat (10) tick();
    set_in(ALU_MFHI, 32'd0, 32'd0, 5'd0, 2'b01, 1'b0, 2'b00, 32'd0, 5'd3, 1'b0);
    reset = 1'b1;
    #1 chk("rstmid_stall_before", {31'd0, stall}, 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, md_busy}, 32'd0);
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_nopo", {31'd0, nopo}, 32'd1);
    $display("txn reset-mid busy %0d stall %0d", md_busy, stall);
    read_hilo(ALU_MFHI, "rstmid_hi", 32'd0);
    read_hilo(ALU_MFLO, "rstmid_lo", 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
